inst_encoder: RTL and testbench

Encodes MIPS-32 instruction fields (R/I/J formats) into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. It is the inverse of the instruction decode path: a field tuple goes in, a packed word comes out. It sits between the testbench/program loader (or a boot ROM sequencer) and the instruction-memory write port, and is used to load programs before the core is released from reset.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/inst_pack.sv | 52 +++++
 rtl/inst_encoder.sv | 144 ++++++++++++++
 tb/tb_inst_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-32 encoding definitions for the encode and decode paths.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_RSV = 2'd3
    } fmt_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // Least-significant bit position of each instruction field
    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int TGT_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } enc_state_e;

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Packs R/I/J field tuples into a 32-bit word; flags tuples that must not be written.
// Latency: combinational. Optional opcode/format checks under INST_ENC_CHECK_EN.
// Backpressure: none (pure function of its inputs).
module inst_pack
    import mips_pkg::*;
(
    input  logic [1:0]  i_fmt,
    input  logic [5:0]  i_opcode,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_func,
    input  logic [15:0] i_immediate,
    input  logic [25:0] i_addr,
    output logic [31:0] o_word,
    output logic        o_fail
);

    // Select the field layout for the format; reserved format always fails
    always_comb begin
        o_word = '0;
        o_fail = 1'b0;
        case (fmt_e'(i_fmt))
            FMT_R: begin
                o_word = (32'(i_opcode) << OP_LSB) | (32'(i_rs) << RS_LSB) |
                         (32'(i_rt) << RT_LSB)     | (32'(i_rd) << RD_LSB) |
                         (32'(i_shamt) << SH_LSB)  | (32'(i_func) << FN_LSB);
`ifdef INST_ENC_CHECK_EN
                o_fail = (i_opcode != OP_RTYPE);
`endif
            end
            FMT_I: begin
                o_word = (32'(i_opcode) << OP_LSB) | (32'(i_rs) << RS_LSB) |
                         (32'(i_rt) << RT_LSB)     | (32'(i_immediate) << IMM_LSB);
`ifdef INST_ENC_CHECK_EN
                o_fail = (i_opcode == OP_RTYPE) || is_jump_op(i_opcode);
`endif
            end
            FMT_J: begin
                o_word = (32'(i_opcode) << OP_LSB) | (32'(i_addr) << TGT_LSB);
`ifdef INST_ENC_CHECK_EN
                o_fail = !is_jump_op(i_opcode);
`endif
            end
            default: begin
                o_fail = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes MIPS field tuples and streams the words to imem at consecutive addresses.
// Latency: tuple accepted in cycle N -> imem_we with registered word in cycle N+1.
// Backpressure: one-word output register; in_ready low while a write is stalled or DEPTH is reached. INST_ENC_CHECK_EN enables opcode checks.
module inst_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       immediate,
    input  logic [25:0]       addr,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W+1:0] LP_DEPTH = (ADDR_W+2)'(DEPTH);

    enc_state_e        r_state;
    enc_state_e        w_state_nxt;
    logic              w_load;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic [31:0]       w_word;
    logic              w_fail;
    logic              w_accept;
    logic              w_wr_done;
    logic              w_last_wr;
    logic [ADDR_W+1:0] w_issued;

    inst_pack u_pack (
        .i_fmt       (fmt),
        .i_opcode    (opcode),
        .i_rs        (rs),
        .i_rt        (rt),
        .i_rd        (rd),
        .i_shamt     (shamt),
        .i_func      (func),
        .i_immediate (immediate),
        .i_addr      (addr),
        .o_word      (w_word),
        .o_fail      (w_fail)
    );

    // Words written plus the one in flight; caps acceptance at DEPTH so the
    // DEPTH-th accept is the last even though its write retires a cycle later.
    assign w_issued  = {1'b0, r_count} + (ADDR_W+2)'(r_we);
    assign w_wr_done = r_we & imem_ready;
    assign w_last_wr = w_wr_done && (({1'b0, r_count} + (ADDR_W+2)'(1)) == LP_DEPTH);
    assign in_ready  = (r_state == ST_RUN) && (w_issued < LP_DEPTH) && (!r_we || imem_ready);
    assign w_accept  = in_valid & in_ready;

    // Next state; stop has priority over start wherever both are honoured
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop)           w_state_nxt = ST_DRAIN;
                else if (w_last_wr) w_state_nxt = ST_FULL;
            end
            ST_DRAIN: begin
                if (!r_we || imem_ready) w_state_nxt = ST_IDLE;
            end
            ST_FULL: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Output word register, address/count tracking and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr  <= base_addr;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (w_wr_done) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W+1)'(1);
            end
            if (w_accept && !w_fail) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
            end else if (w_wr_done) begin
                r_we    <= 1'b0;
            end
            if (w_accept && w_fail) r_err <= 1'b1;
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = (r_state == ST_FULL);
    assign err        = r_err;

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] immediate;
    logic [25:0] addr;
    logic        imem_we;
    logic        imem_ready;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;
    logic        full;
    logic        err;

    int vectors;
    int miscompares;

    inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .func       (func),
        .immediate  (immediate),
        .addr       (addr),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoding built from field weights (powers of two)
    function automatic logic [31:0] model_word(input int f, input int op, input int s, input int t,
                                               input int d, input int sh, input int fn,
                                               input int imm, input int ad);
        longint w;
        w = 0;
        if (f == 0)      w = op * 64'd67108864 + s * 64'd2097152 + t * 64'd65536 + d * 64'd2048 + sh * 64'd64 + fn;
        else if (f == 1) w = op * 64'd67108864 + s * 64'd2097152 + t * 64'd65536 + imm;
        else if (f == 2) w = op * 64'd67108864 + ad;
        return w[31:0];
    endfunction

    function automatic bit model_ok(input int f, input int op);
        if (f == 3) return 1'b0;
`ifdef INST_ENC_CHECK_EN
        if (f == 0) return op == 0;
        if (f == 2) return (op == 2) || (op == 3);
        return !((op == 0) || (op == 2) || (op == 3));
`else
        return 1'b1;
`endif
    endfunction

    task automatic set_fields(input int f, input int op, input int s, input int t, input int d,
                              input int sh, input int fn, input int imm, input int ad);
        fmt = 2'(f); opcode = 6'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d);
        shamt = 5'(sh); func = 6'(fn); immediate = 16'(imm); addr = 26'(ad);
    endtask

    // Present one tuple and return at posedge+1 right after it is accepted
    task automatic send(input int f, input int op, input int s, input int t, input int d,
                        input int sh, input int fn, input int imm, input int ad);
        int n;
        set_fields(f, op, s, t, d, sh, fn, imm, ad);
        in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        vectors++;
        if (n >= 50) begin miscompares++; $display("FAIL send_timeout in_ready stayed %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] b);
        start = 1'b1; base_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic restart(input logic [9:0] b);
        in_valid = 1'b0; imem_ready = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_start(b);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; stop = 0; base_addr = '0; in_valid = 0; imem_ready = 0;
        set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        vectors++; if ({in_ready, imem_we, full, err} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {in_ready, imem_we, full, err}); end
        vectors++; if (imem_addr !== 10'h0 || count !== 11'h0) begin miscompares++; $display("FAIL reset_addr_count got %h/%h want 0/0", imem_addr, count); end
        vectors++; if (imem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_r_write;
        restart(10'h010);
        send(0, 0, 8, 9, 10, 0, 6'h20, 0, 0);
        vectors++; if (imem_we !== 1'b1) begin miscompares++; $display("FAIL r_we got %b want 1", imem_we); end
        vectors++; if (imem_wdata !== 32'h01095020) begin miscompares++; $display("FAIL r_wdata got %h want 01095020", imem_wdata); end
        vectors++; if (imem_addr !== 10'h010) begin miscompares++; $display("FAIL r_addr got %h want 010", imem_addr); end
        @(posedge clk); #1;
        vectors++; if (imem_we !== 1'b0 || count !== 11'd1) begin miscompares++; $display("FAIL r_done we/count got %b/%0d want 0/1", imem_we, count); end
    endtask

    task automatic test_back_to_back;
        restart(10'h020);
        send(1, 6'h08, 0, 8, 0, 0, 0, 5, 0);
        vectors++; if (imem_wdata !== 32'h20080005 || imem_addr !== 10'h020) begin miscompares++; $display("FAIL b2b_first got %h@%h want 20080005@020", imem_wdata, imem_addr); end
        send(1, 6'h23, 29, 9, 0, 0, 0, 4, 0);
        vectors++; if (imem_wdata !== 32'h8FA90004 || imem_addr !== 10'h021) begin miscompares++; $display("FAIL b2b_second got %h@%h want 8fa90004@021", imem_wdata, imem_addr); end
        vectors++; if (count !== 11'd1 || imem_we !== 1'b1) begin miscompares++; $display("FAIL b2b_mid count/we got %0d/%b want 1/1", count, imem_we); end
        @(posedge clk); #1;
        vectors++; if (count !== 11'd2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", count); end
    endtask

    task automatic test_stall;
        restart(10'h040);
        imem_ready = 1'b0;
        send(2, 2, 0, 0, 0, 0, 0, 0, 26'h0100000);
        set_fields(1, 6'h08, 1, 2, 0, 0, 0, 7, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (imem_we !== 1'b1 || imem_wdata !== 32'h08100000 || imem_addr !== 10'h040) begin miscompares++; $display("FAIL stall_hold%0d got %b %h@%h want 1 08100000@040", k, imem_we, imem_wdata, imem_addr); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready%0d got %b want 0", k, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        imem_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (imem_we !== 1'b0 || count !== 11'd1) begin miscompares++; $display("FAIL stall_release we/count got %b/%0d want 0/1", imem_we, count); end
    endtask

    task automatic test_full;
        int acc;
        restart(10'h100);
        set_fields(1, 6'h08, 0, 8, 0, 0, 0, 1, 0);
        in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        vectors++; if (acc !== DEPTH) begin miscompares++; $display("FAIL full_accepts got %0d want %0d", acc, DEPTH); end
        vectors++; if (full !== 1'b1 || count !== 11'(DEPTH)) begin miscompares++; $display("FAIL full_flag full/count got %b/%0d want 1/%0d", full, count, DEPTH); end
        vectors++; if (imem_addr !== 10'h104) begin miscompares++; $display("FAIL full_addr got %h want 104", imem_addr); end
        do_start(10'h000);
        #1;
        vectors++; if (full !== 1'b0 || count !== 11'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL full_restart full/count/rdy got %b/%0d/%b want 0/0/1", full, count, in_ready); end
    endtask

    task automatic test_check;
        restart(10'h080);
        send(0, 6'h08, 8, 9, 10, 0, 6'h20, 0, 0);
`ifdef INST_ENC_CHECK_EN
        vectors++; if (imem_we !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL chk_reject we/err got %b/%b want 0/1", imem_we, err); end
        send(0, 0, 8, 9, 10, 0, 6'h20, 0, 0);
        vectors++; if (imem_we !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL chk_sticky we/err got %b/%b want 1/1", imem_we, err); end
`else
        vectors++; if (imem_we !== 1'b1 || imem_wdata !== 32'h21095020) begin miscompares++; $display("FAIL nochk_write got %b %h want 1 21095020", imem_we, imem_wdata); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL nochk_err got %b want 0", err); end
`endif
    endtask

    task automatic test_fmt3;
        restart(10'h0C0);
        send(3, 6'h08, 1, 2, 3, 4, 5, 6, 7);
        vectors++; if (imem_we !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL fmt3 we/err got %b/%b want 0/1", imem_we, err); end
        @(posedge clk); #1;
        vectors++; if (count !== 11'd0 || err !== 1'b1) begin miscompares++; $display("FAIL fmt3_hold count/err got %0d/%b want 0/1", count, err); end
        restart(10'h0C0);
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL fmt3_clear err got %b want 0", err); end
    endtask

    task automatic test_wrap;
        restart(10'h3FE);
        send(1, 6'h0D, 1, 1, 0, 0, 0, 16'h00FF, 0);
        vectors++; if (imem_addr !== 10'h3FE) begin miscompares++; $display("FAIL wrap0 got %h want 3fe", imem_addr); end
        send(1, 6'h0D, 1, 1, 0, 0, 0, 16'h00FE, 0);
        vectors++; if (imem_addr !== 10'h3FF) begin miscompares++; $display("FAIL wrap1 got %h want 3ff", imem_addr); end
        send(1, 6'h0D, 1, 1, 0, 0, 0, 16'h00FD, 0);
        vectors++; if (imem_addr !== 10'h000 || imem_wdata !== 32'h342100FD) begin miscompares++; $display("FAIL wrap2 got %h@%h want 342100fd@000", imem_wdata, imem_addr); end
    endtask

    task automatic test_stop;
        restart(10'h200);
        imem_ready = 1'b0;
        send(1, 6'h08, 0, 1, 0, 0, 0, 3, 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        set_fields(1, 6'h08, 0, 2, 0, 0, 0, 3, 0);
        in_valid = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0 || imem_we !== 1'b1) begin miscompares++; $display("FAIL drain rdy/we got %b/%b want 0/1", in_ready, imem_we); end
        imem_ready = 1'b1;
        @(posedge clk); #1;
        vectors++; if (imem_we !== 1'b0 || in_ready !== 1'b0 || count !== 11'd1) begin miscompares++; $display("FAIL drain_done we/rdy/count got %b/%b/%0d want 0/0/1", imem_we, in_ready, count); end
        start = 1'b1; stop = 1'b1; base_addr = 10'h222;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b0 || imem_addr !== 10'h201) begin miscompares++; $display("FAIL start_stop rdy/addr got %b/%h want 0/201", in_ready, imem_addr); end
        in_valid = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] q[$];
        int m_addr, m_count, f, op;
        bit m_err, m_rdy;
        for (int seg = 0; seg < 12; seg++) begin
            m_addr = $urandom_range(0, 1023);
            restart(10'(m_addr));
            m_count = 0; m_err = 0; q.delete();
            for (int cyc = 0; cyc < 30; cyc++) begin
                imem_ready = ($urandom_range(0, 3) != 0);
                in_valid = $urandom_range(0, 1);
                f = $urandom_range(0, 9);
                f = (f < 3) ? 0 : (f < 6) ? 1 : (f < 9) ? 2 : 3;
                if ($urandom_range(0, 1) == 1) op = $urandom_range(0, 63);
                else op = (f == 0) ? 0 : (f == 2) ? $urandom_range(2, 3) : $urandom_range(4, 63);
                set_fields(f, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                           $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                           $urandom_range(0, 67108863));
                #3;
                m_rdy = (m_count + q.size() < DEPTH) && (q.size() == 0 || imem_ready);
                vectors++; if (in_ready !== m_rdy) begin miscompares++; $display("FAIL rnd_in_ready seg%0d cyc%0d got %b want %b", seg, cyc, in_ready, m_rdy); end
                vectors++; if (imem_we !== (q.size() != 0)) begin miscompares++; $display("FAIL rnd_we seg%0d cyc%0d got %b want %b", seg, cyc, imem_we, q.size() != 0); end
                if (q.size() != 0) begin
                    vectors++; if (imem_wdata !== q[0] || imem_addr !== 10'(m_addr)) begin miscompares++; $display("FAIL rnd_word seg%0d cyc%0d got %h@%h want %h@%h", seg, cyc, imem_wdata, imem_addr, q[0], 10'(m_addr)); end
                end
                vectors++; if (count !== 11'(m_count) || full !== (m_count == DEPTH) || err !== m_err) begin miscompares++; $display("FAIL rnd_status seg%0d cyc%0d count/full/err got %0d/%b/%b want %0d/%b/%b", seg, cyc, count, full, err, m_count, m_count == DEPTH, m_err); end
                if (q.size() != 0 && imem_ready) begin
                    void'(q.pop_front());
                    m_addr = (m_addr + 1) % 1024;
                    m_count++;
                end
                if (in_valid && m_rdy) begin
                    if (model_ok(f, op)) q.push_back(model_word(f, op, rs, rt, rd, shamt, func, immediate, addr));
                    else m_err = 1'b1;
                end
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        restart(10'h300);
        imem_ready = 1'b0;
        send(1, 6'h08, 0, 1, 0, 0, 0, 9, 0);
        vectors++; if (imem_we !== 1'b1) begin miscompares++; $display("FAIL arst_pre we got %b want 1", imem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if ({in_ready, imem_we, full, err} !== 4'b0 || imem_addr !== 10'h0) begin miscompares++; $display("FAIL arst_flags got %b addr %h want 0000 addr 000", {in_ready, imem_we, full, err}, imem_addr); end
        vectors++; if (imem_wdata !== 32'h0 || count !== 11'h0) begin miscompares++; $display("FAIL arst_data got %h count %0d want 0/0", imem_wdata, count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_r_write();
        test_back_to_back();
        test_stall();
        test_full();
        test_check();
        test_fmt3();
        test_wrap();
        test_stop();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
